// File: rtl/spi_cmd_decoder_pkg.sv
// Shared opcode constants and FSM state encoding for the SPI command decoder.
package spi_cmd_decoder_pkg;

    localparam logic [7:0] OPC_WREG = 8'h01;
    localparam logic [7:0] OPC_WFB  = 8'h02;

    typedef enum logic [3:0] {
        StIdle,
        StOpc,
        StRaddr,
        StRdata,
        StFaddrH,
        StFaddrL,
        StPixH,
        StPixL,
        StDiscard
    } state_e;

endpackage

// File: rtl/spi_cmd_decoder_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with single-cycle edge pulses.
module spi_sync_edge #(
    parameter bit ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= ResetVal;
            s2_q <= ResetVal;
            s3_q <= ResetVal;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign q_o    = s2_q;
    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Frame parser for SPI command bytes: register writes and auto-incrementing pixel writes.
// Optional frame timeout abort is enabled by defining SPICMD_TIMEOUT_EN.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int unsigned FB_AW   = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic [7:0]       rx_byte,
    input  logic             rx_dr,
    output logic             reg_we,
    output logic [7:0]       reg_addr,
    output logic [7:0]       reg_wdata,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [15:0]      fb_wdata,
    output logic             busy,
    output logic             err
);

    logic cs_q, cs_rise, cs_fall;
    logic dr_q, byte_ev, dr_fall;

    // cs_n idles high, so its synchroniser resets high to avoid a phantom frame start.
    spi_sync_edge #(.ResetVal(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (cs_n),
        .q_o    (cs_q),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.ResetVal(1'b0)) u_sync_dr (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (rx_dr),
        .q_o    (dr_q),
        .rise_o (byte_ev),
        .fall_o (dr_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{cs_rise, cs_fall, dr_q, dr_fall};

    state_e           state_q, state_d;
    logic             reg_we_q, reg_we_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic [7:0]       reg_wdata_q, reg_wdata_d;
    logic             fb_we_q, fb_we_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [15:0]      fb_wdata_q, fb_wdata_d;
    logic             err_q, err_d;
    logic [FB_AW-1:0] fb_cnt_q, fb_cnt_d;
    logic [7:0]       addr_hi_q, addr_hi_d;
    logic [7:0]       pix_hi_q, pix_hi_d;
    logic [15:0]      faddr_full;

    assign faddr_full = {addr_hi_q, rx_byte};

`ifdef SPICMD_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);
    logic [TmoW-1:0] tmo_q, tmo_d;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    always_comb begin
        state_d     = state_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_wdata_d  = fb_wdata_q;
        err_d       = 1'b0;
        fb_cnt_d    = fb_cnt_q;
        addr_hi_d   = addr_hi_q;
        pix_hi_d    = pix_hi_q;

        if (state_q == StIdle) begin
            if (!cs_q) state_d = StOpc;
        end else if (byte_ev) begin
            unique case (state_q)
                StOpc: begin
                    if (rx_byte == OPC_WREG) begin
                        state_d = StRaddr;
                    end else if (rx_byte == OPC_WFB) begin
                        state_d = StFaddrH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDiscard;
                    end
                end
                StRaddr: begin
                    reg_addr_d = rx_byte;
                    state_d    = StRdata;
                end
                StRdata: begin
                    reg_we_d    = 1'b1;
                    reg_wdata_d = rx_byte;
                    state_d     = StDiscard;
                end
                StFaddrH: begin
                    addr_hi_d = rx_byte;
                    state_d   = StFaddrL;
                end
                StFaddrL: begin
                    fb_cnt_d = faddr_full[FB_AW-1:0];
                    state_d  = StPixH;
                end
                StPixH: begin
                    pix_hi_d = rx_byte;
                    state_d  = StPixL;
                end
                StPixL: begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = fb_cnt_q;
                    fb_wdata_d = {pix_hi_q, rx_byte};
                    fb_cnt_d   = fb_cnt_q + 1'b1;
                    state_d    = StPixH;
                end
                default: ;
            endcase
        end

`ifdef SPICMD_TIMEOUT_EN
        // Counter saturates so a stalled DISCARD does not re-fire until another byte arrives.
        tmo_d = tmo_q;
        if (state_q == StIdle || byte_ev) begin
            tmo_d = '0;
        end else if (tmo_q != TmoMax) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TmoMax) begin
                err_d   = 1'b1;
                state_d = StDiscard;
            end
        end
`endif

        // Frame end overrides any byte decoded in the same cycle.
        if (state_q != StIdle && cs_q) begin
            state_d  = StIdle;
            reg_we_d = 1'b0;
            fb_we_d  = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_wdata_q  <= '0;
            err_q       <= 1'b0;
            fb_cnt_q    <= '0;
            addr_hi_q   <= '0;
            pix_hi_q    <= '0;
`ifdef SPICMD_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_wdata_q  <= fb_wdata_d;
            err_q       <= err_d;
            fb_cnt_q    <= fb_cnt_d;
            addr_hi_q   <= addr_hi_d;
            pix_hi_q    <= pix_hi_d;
`ifdef SPICMD_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_wdata  = fb_wdata_q;
    assign err       = err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: expected writes queued at stimulus, checked at strobes.
module tb_spi_cmd_decoder;

    localparam int unsigned FbAw = 16;
`ifdef SPICMD_TIMEOUT_EN
    localparam int unsigned Tmo = 64;
`else
    localparam int unsigned Tmo = 4096;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cs_n = 1'b1;
    logic [7:0]      rx_byte = 8'h00;
    logic            rx_dr = 1'b0;
    logic            reg_we;
    logic [7:0]      reg_addr;
    logic [7:0]      reg_wdata;
    logic            fb_we;
    logic [FbAw-1:0] fb_addr;
    logic [15:0]     fb_wdata;
    logic            busy;
    logic            err;

    spi_cmd_decoder #(.FB_AW(FbAw), .TIMEOUT(Tmo)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .rx_byte   (rx_byte),
        .rx_dr     (rx_dr),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic [15:0] reg_q[$];
    logic [31:0] fb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_we) begin
                if (reg_q.size() == 0) check_eq("reg_we_unexpected", 32'd1, 32'd0);
                else check_eq("reg_write", {16'h0, reg_addr, reg_wdata}, {16'h0, reg_q.pop_front()});
            end
            if (fb_we) begin
                if (fb_q.size() == 0) check_eq("fb_we_unexpected", 32'd1, 32'd0);
                else check_eq("fb_write", {fb_addr, fb_wdata}, fb_q.pop_front());
            end
            if (err) err_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b;
        rx_dr   = 1'b1;
        repeat (4) @(posedge clk);
        #1 rx_dr = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic frame_start();
        @(posedge clk); #1 cs_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic frame_end();
        @(posedge clk); #1 cs_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_reg_left"}, reg_q.size(), 0);
        check_eq({tag, "_fb_left"}, fb_q.size(), 0);
        check_eq({tag, "_err_count"}, err_seen, err_exp);
        check_eq({tag, "_busy_idle"}, {31'h0, busy}, 0);
    endtask

    initial begin
        int n;
        #12;
        check_eq("rst_outputs", {reg_we, fb_we, err, busy}, 4'h0);
        check_eq("rst_data", {reg_addr, reg_wdata, fb_wdata}, 32'h0);
        check_eq("rst_fb_addr", {16'h0, fb_addr}, 32'h0);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Single register write, trailing byte ignored.
        frame_start();
        reg_q.push_back(16'h3A5C);
        send_byte(8'h01); send_byte(8'h3A); send_byte(8'h5C); send_byte(8'h99);
        frame_end();
        check_drained("t1");

        // Pixel stream with auto-increment.
        frame_start();
        fb_q.push_back({16'h0010, 16'hABCD});
        fb_q.push_back({16'h0011, 16'h1234});
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h12); send_byte(8'h34);
        frame_end();
        check_drained("t2");

        // Address counter wraps.
        frame_start();
        fb_q.push_back({16'hFFFF, 16'hAABB});
        fb_q.push_back({16'h0000, 16'hCCDD});
        send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        frame_end();
        check_drained("t3");

        // Unknown opcode: err exactly one clk after the byte event.
        frame_start();
        @(posedge clk); #1;
        rx_byte = 8'h7E;
        rx_dr   = 1'b1;
        err_exp++;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) check_eq("t4_err_early", {31'h0, err}, 0);
        @(negedge clk) check_eq("t4_err_latency", {31'h0, err}, 1);
        @(negedge clk) check_eq("t4_err_single", {31'h0, err}, 0);
        #1 rx_dr = 1'b0;
        repeat (4) @(posedge clk);
        send_byte(8'h01); send_byte(8'h3A); send_byte(8'h5C);
        frame_end();
        check_drained("t4");

        // Pixel stream cut mid-pixel; half pixel discarded.
        frame_start();
        fb_q.push_back({16'h0020, 16'hABCD});
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
        @(posedge clk); #1 cs_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) check_eq("t5_busy_drop", {31'h0, busy}, 0);
        repeat (4) @(posedge clk);
        frame_start();
        reg_q.push_back(16'h0203);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        frame_end();
        check_drained("t5");

        // Asynchronous reset mid-pixel.
        frame_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'hAB);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_outputs", {reg_we, fb_we, err, busy}, 4'h0);
        check_eq("t6_rst_data", {reg_addr, reg_wdata, fb_wdata}, 32'h0);
        cs_n = 1'b1;
        #20 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        check_drained("t6");

`ifdef SPICMD_TIMEOUT_EN
        // Stalled frame aborts after TIMEOUT idle cycles; later bytes ignored.
        frame_start();
        send_byte(8'h02); send_byte(8'h00);
        err_exp++;
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t7_tmo_window", {31'h0, (n >= 50 && n <= 70)}, 1);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        frame_end();
        check_drained("t7");
`else
        n = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
